// File: rtl/mac_unit.sv
// Signed multiply-accumulate unit for the CNN convolution datapath.
// Accumulates activation*weight over a valid burst, then presents accumulator+bias on a valid/ready handshake.
module mac_unit #(
  parameter int unsigned INPUT_BIT_RESOLUTION  = 8,
  parameter int unsigned OUTPUT_BIT_RESOLUTION = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clr_i,
  input  logic                                    input_and_kernel_valid_i,
  input  logic signed [INPUT_BIT_RESOLUTION-1:0]  input_data_i,
  input  logic signed [INPUT_BIT_RESOLUTION-1:0]  kernel_weight_i,
  input  logic signed [OUTPUT_BIT_RESOLUTION-1:0] kernel_bias_i,
  output logic                                    mac_valid_o,
  output logic signed [OUTPUT_BIT_RESOLUTION-1:0] mac_data_o,
  input  logic                                    mac_ready_i
);

  localparam int unsigned IW = INPUT_BIT_RESOLUTION;
  localparam int unsigned OW = OUTPUT_BIT_RESOLUTION;
  localparam int unsigned PW = 2 * INPUT_BIT_RESOLUTION;

  // The full-precision product must fit in the accumulator.
  if (OW < PW) begin : g_width_check
    $error("mac_unit: OUTPUT_BIT_RESOLUTION must be >= 2*INPUT_BIT_RESOLUTION");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_next;

  logic signed [PW-1:0] product;
  logic signed [OW-1:0] product_ext;
  logic signed [OW-1:0] acc_q;
  logic signed [OW-1:0] bias_q;

  logic acc_load;
  logic acc_add;
  logic acc_zero;
  logic bias_load;
  logic result_set;
  logic result_clear;

  assign product     = input_data_i * kernel_weight_i;
  assign product_ext = OW'(product);

  // State register; reset and clear both abandon any partial sum.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (input_and_kernel_valid_i) state_next = ACCUM;
      end
      ACCUM: begin
        if (!input_and_kernel_valid_i) state_next = DONE;
      end
      DONE: begin
        if (mac_ready_i) state_next = input_and_kernel_valid_i ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath control decode.
  always_comb begin
    acc_load     = 1'b0;
    acc_add      = 1'b0;
    acc_zero     = 1'b0;
    bias_load    = 1'b0;
    result_set   = 1'b0;
    result_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_and_kernel_valid_i) begin
          acc_load  = 1'b1;
          bias_load = 1'b1;
        end
      end
      ACCUM: begin
        if (input_and_kernel_valid_i) begin
          acc_add   = 1'b1;
          bias_load = 1'b1;
        end else begin
          result_set = 1'b1;
        end
      end
      DONE: begin
        // Samples arriving while the result is stalled are dropped.
        if (mac_ready_i) begin
          result_clear = 1'b1;
          if (input_and_kernel_valid_i) begin
            acc_load  = 1'b1;
            bias_load = 1'b1;
          end else begin
            acc_zero = 1'b1;
          end
        end
      end
      default: begin
        acc_zero = 1'b1;
      end
    endcase
  end

  // Accumulator, bias and result registers; sums wrap modulo 2^OW.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      bias_q      <= '0;
      mac_valid_o <= 1'b0;
      mac_data_o  <= '0;
    end else if (clr_i) begin
      acc_q       <= '0;
      bias_q      <= '0;
      mac_valid_o <= 1'b0;
    end else begin
      if (acc_load) begin
        acc_q <= product_ext;
      end else if (acc_add) begin
        acc_q <= acc_q + product_ext;
      end else if (acc_zero) begin
        acc_q <= '0;
      end
      if (bias_load) bias_q <= kernel_bias_i;
      if (result_set) begin
        mac_valid_o <= 1'b1;
        mac_data_o  <= acc_q + bias_q;
      end else if (result_clear) begin
        mac_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios plus randomized traffic against a
// transaction-level reference (queue of accepted products, last bias, pending result).
module tb_mac_unit;

  logic               clk;
  logic               rst;
  logic               clr;
  logic               valid;
  logic signed [7:0]  data;
  logic signed [7:0]  weight;
  logic signed [31:0] bias;
  logic               mac_valid;
  logic signed [31:0] mac_data;
  logic               ready;

  // 16-bit accumulator instance for the wrap scenario
  logic               w_rst;
  logic               w_valid;
  logic signed [7:0]  w_data;
  logic signed [7:0]  w_weight;
  logic signed [15:0] w_bias;
  logic               w_mac_valid;
  logic signed [15:0] w_mac_data;
  logic               w_ready;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint prods[$];
  longint last_bias = 0;
  bit     pending   = 0;
  bit     exp_valid = 0;
  longint exp_data  = 0;

  mac_unit #(.INPUT_BIT_RESOLUTION(8), .OUTPUT_BIT_RESOLUTION(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .input_and_kernel_valid_i(valid),
    .input_data_i(data), .kernel_weight_i(weight), .kernel_bias_i(bias),
    .mac_valid_o(mac_valid), .mac_data_o(mac_data), .mac_ready_i(ready)
  );

  mac_unit #(.INPUT_BIT_RESOLUTION(8), .OUTPUT_BIT_RESOLUTION(16)) u_wrap (
    .clk_i(clk), .rst_i(w_rst), .clr_i(1'b0),
    .input_and_kernel_valid_i(w_valid),
    .input_data_i(w_data), .kernel_weight_i(w_weight), .kernel_bias_i(w_bias),
    .mac_valid_o(w_mac_valid), .mac_data_o(w_mac_data), .mac_ready_i(w_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sum_q();
    longint s = 0;
    foreach (prods[i]) s += prods[i];
    return s;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: advance one clock with the given inputs.
  task automatic model_step(input bit r, input bit c, input bit v, input longint p,
                            input longint b, input bit rdy);
    if (r) begin
      prods.delete(); last_bias = 0; pending = 0; exp_valid = 0; exp_data = 0;
    end else if (c) begin
      prods.delete(); last_bias = 0; pending = 0; exp_valid = 0;
    end else if (pending) begin
      if (rdy) begin
        pending = 0; exp_valid = 0; prods.delete();
        if (v) begin prods.push_back(p); last_bias = b; end
      end
    end else if (v) begin
      prods.push_back(p); last_bias = b;
    end else if (prods.size() > 0) begin
      exp_data  = wrap(sum_q() + last_bias, 32);
      exp_valid = 1; pending = 1; prods.delete();
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input int a, input int k,
                       input int b, input bit rdy, input string tag);
    @(negedge clk);
    rst = r; clr = c; valid = v; ready = rdy;
    data = 8'(a); weight = 8'(k); bias = 32'(b);
    model_step(r, c, v, longint'(data) * longint'(weight), longint'(bias), rdy);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, longint'(mac_valid), longint'(exp_valid));
    chk({tag, "_data"}, longint'(mac_data), exp_data);
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1; clr = 0; valid = 0; data = 0; weight = 0; bias = 0; ready = 0;
    w_rst = 1; w_valid = 0; w_data = 0; w_weight = 0; w_bias = 0; w_ready = 0;

    // reset with random inputs, then idle
    for (int i = 0; i < 10; i++)
      cycle(1, 0, 1'($urandom), rnd8(), rnd8(), int'($urandom), 1'($urandom), "reset");
    chk("reset_valid_const", longint'(mac_valid), 0);
    chk("reset_data_const", longint'(mac_data), 0);
    w_rst = 0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, "idle");

    // basic dot product
    cycle(0, 0, 1, 0, 0, 10, 0, "dot_zero");
    cycle(0, 0, 1, 0, 0, 10, 0, "dot_zero");
    for (int i = 3; i <= 6; i++) cycle(0, 0, 1, i, i, 10, 0, "dot_acc");
    cycle(0, 0, 0, 7, 7, 10, 0, "dot_drop");
    chk("dot_result_valid", longint'(mac_valid), 1);
    chk("dot_result_96", longint'(mac_data), 96);
    cycle(0, 0, 0, 0, 0, 0, 1, "dot_ready");
    chk("dot_after_hs_valid", longint'(mac_valid), 0);
    chk("dot_after_hs_data", longint'(mac_data), 96);

    // signed values with backpressure; samples during the stall are dropped
    cycle(0, 0, 1, -3, 5, -1, 0, "sgn_acc");
    cycle(0, 0, 1, 127, -128, -1, 0, "sgn_acc");
    cycle(0, 0, 0, 0, 0, 0, 0, "sgn_drop");
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 1'(i & 1), rnd8(), rnd8(), int'($urandom), 0, "sgn_stall");
    chk("sgn_hold_valid", longint'(mac_valid), 1);
    chk("sgn_hold_data", longint'(mac_data), -16272);
    cycle(0, 0, 0, 0, 0, 0, 1, "sgn_ready");

    // clear mid-accumulation
    cycle(0, 0, 1, 2, 2, 0, 0, "clr_acc");
    cycle(0, 0, 1, 2, 2, 0, 0, "clr_acc");
    cycle(0, 1, 1, 9, 9, 5, 1, "clr_pulse");
    cycle(0, 0, 1, 1, 1, 0, 0, "clr_after");
    cycle(0, 0, 0, 0, 0, 0, 0, "clr_drop");
    chk("clr_result_1", longint'(mac_data), 1);
    cycle(0, 0, 0, 0, 0, 0, 1, "clr_ready");

    // back-to-back: ready and a new sample in the same cycle
    cycle(0, 0, 1, 1, 2, 0, 0, "b2b_first");
    cycle(0, 0, 0, 0, 0, 0, 0, "b2b_drop1");
    chk("b2b_result_2", longint'(mac_data), 2);
    cycle(0, 0, 1, 2, 3, 0, 1, "b2b_overlap");
    chk("b2b_valid_low", longint'(mac_valid), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, "b2b_drop2");
    chk("b2b_result_6", longint'(mac_data), 6);
    cycle(0, 0, 0, 0, 0, 0, 1, "b2b_ready");

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 2) != 0), rnd8(), rnd8(), int'($urandom),
            1'($urandom_range(0, 1)), "rand");

    // wrap on the 16-bit accumulator
    @(negedge clk);
    w_valid = 1; w_data = 127; w_weight = 127; w_bias = 0;
    repeat (3) @(negedge clk);
    w_valid = 0;
    @(posedge clk);
    #1;
    chk("wrap_valid", longint'(w_mac_valid), 1);
    chk("wrap_data", longint'(w_mac_data), -17149);
    chk("wrap_model", longint'(w_mac_data), wrap(3 * 127 * 127, 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
